// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the memory-side responder.
//   DATA_W  - data bus / memory word width
//   ADDR_W  - address width (PC and IR address field)
//   SW_W    - width of the switch input
//   IO_BASE - first MMIO address; RAM occupies 0 .. IO_BASE-1
//   IO_*    - MMIO register offsets relative to IO_BASE
//   BUS_*   - data_bus_sel source encodings
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int SW_W   = 8;

    localparam logic [ADDR_W-1:0] IO_BASE = 8'hF0;

    localparam logic [ADDR_W-1:0] IO_LED  = 8'd0;
    localparam logic [ADDR_W-1:0] IO_SW   = 8'd1;
    localparam logic [ADDR_W-1:0] IO_CNT  = 8'd2;
    localparam logic [ADDR_W-1:0] IO_STAT = 8'd3;

    localparam logic [1:0] BUS_ALU = 2'b00;
    localparam logic [1:0] BUS_MEM = 2'b01;
    localparam logic [1:0] BUS_RF  = 2'b10;

    // Anything at or above IO_BASE belongs to the MMIO window.
    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return (a >= IO_BASE);
    endfunction

endpackage

// File: rtl/mem_bus_responder_mmio_regs.sv
// mmio_regs: memory-mapped I/O registers of the responder.
//   clk, reset_n  - clock, asynchronous active-low reset
//   run_i         - high while the CPU runs (counter enable, status bit)
//   wr_en_i       - controller write into the MMIO window this cycle
//   off_i         - address offset from IO_BASE
//   wdata_i       - write data
//   sw_in_i       - asynchronous switch inputs
//   led_o         - LED register
//   rdata_o       - combinational read data for off_i
module mmio_regs
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [SW_W-1:0]   sw_in_i,
    output logic [DATA_W-1:0] led_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;

    always_comb begin
        led_d = led_q;
        if (wr_en_i && off_i == IO_LED) begin
            led_d = wdata_i;
        end
    end

    // A write to the counter clears it and takes priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en_i && off_i == IO_CNT) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= '0;
            cnt_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            sw_s1_q <= sw_in_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            IO_LED:  rdata_o = led_q;
            IO_SW:   rdata_o = {{(DATA_W-SW_W){1'b0}}, sw_s2_q};
            IO_CNT:  rdata_o = cnt_q;
            IO_STAT: rdata_o = {{(DATA_W-1){1'b0}}, run_i};
            default: rdata_o = '0;
        endcase
    end

    assign led_o = led_q;

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory side of the processor bus.
//   Selects pc or ir_addr, reads RAM/MMIO combinationally, commits writes
//   at the clock edge, and runs the boot phase (loader fills RAM while the
//   CPU is held, ld_done releases it into RUN; only reset returns to BOOT).
//   clk, reset_n                 - clock, asynchronous active-low reset
//   pc, ir_addr, mem_addr_sel    - address sources and select (1 = ir_addr)
//   mem_write, wdata             - controller write strobe and data
//   data_bus_sel, rdata, mem_drive - bus source select, read data, drive flag
//   sw_in, led_out               - switch inputs, LED register
//   ld_valid/ld_addr/ld_data/ld_done/ld_ready - boot loader port
//   cpu_hold, boot_done          - CPU hold (BOOT) and RUN indication
module mem_bus_responder
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic              mem_addr_sel,
    input  logic              mem_write,
    input  logic [1:0]        data_bus_sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_drive,
    input  logic [SW_W-1:0]   sw_in,
    output logic [DATA_W-1:0] led_out,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              boot_done
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         RAM_DEPTH = int'(IO_BASE);

    logic [0:0] state_q, state_d;
    logic       run;

    logic [ADDR_W-1:0] addr;
    logic              addr_is_io;
    logic [ADDR_W-1:0] io_off;
    logic [DATA_W-1:0] io_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];

    // Boot FSM; boot_done is the state bit made visible.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && ld_done) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign cpu_hold  = ~run;
    assign boot_done = run;
    assign ld_ready  = ~run;
    assign mem_drive = run && (data_bus_sel == BUS_MEM);

    assign addr       = mem_addr_sel ? ir_addr : pc;
    assign addr_is_io = is_io(addr);
    assign io_off     = addr - IO_BASE;

    // The RAM write port belongs to the loader in BOOT and to the controller
    // in RUN; writes aimed at the MMIO window never reach the array.
    always_comb begin
        if (run) begin
            ram_we    = mem_write && !addr_is_io;
            ram_waddr = addr;
            ram_wdata = wdata;
        end else begin
            ram_we    = ld_valid && !is_io(ld_addr);
            ram_waddr = ld_addr;
            ram_wdata = ld_data;
        end
    end

    // Contents survive reset so a warm restart only needs ld_done.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    mmio_regs u_mmio (
        .clk     (clk),
        .reset_n (reset_n),
        .run_i   (run),
        .wr_en_i (run && mem_write && addr_is_io),
        .off_i   (io_off),
        .wdata_i (wdata),
        .sw_in_i (sw_in),
        .led_o   (led_out),
        .rdata_o (io_rdata)
    );

    // Asynchronous read: a same-cycle write shows up only after the edge.
    always_comb begin
        if (addr_is_io) begin
            rdata = io_rdata;
        end else begin
            rdata = ram_q[addr];
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam int W = 36;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pc, ir_addr;
  logic        mem_addr_sel, mem_write;
  logic [1:0]  data_bus_sel;
  logic [15:0] wdata, rdata;
  logic        mem_drive;
  logic [7:0]  sw_in;
  logic [15:0] led_out;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_done, ld_ready, cpu_hold, boot_done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  // reference model state
  bit          m_run;
  logic [15:0] m_mem[0:239];
  logic [15:0] m_led, m_cnt;
  logic [7:0]  m_sw_mid, m_sw_old;

  // clock/reset block
  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc           (pc),
    .ir_addr      (ir_addr),
    .mem_addr_sel (mem_addr_sel),
    .mem_write    (mem_write),
    .data_bus_sel (data_bus_sel),
    .wdata        (wdata),
    .rdata        (rdata),
    .mem_drive    (mem_drive),
    .sw_in        (sw_in),
    .led_out      (led_out),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_done      (ld_done),
    .ld_ready     (ld_ready),
    .cpu_hold     (cpu_hold),
    .boot_done    (boot_done)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_read(input logic [7:0] a);
    if (a < 8'hF0) return m_mem[a];
    case (a)
      8'hF0:   return m_led;
      8'hF1:   return {8'h00, m_sw_old};
      8'hF2:   return m_cnt;
      8'hF3:   return {15'h0, m_run};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_run    = 1'b0;
    m_led    = 16'h0;
    m_cnt    = 16'h0;
    m_sw_mid = 8'h0;
    m_sw_old = 8'h0;
  endtask

  task automatic model_edge();
    logic [7:0] a;
    a = mem_addr_sel ? ir_addr : pc;
    if (!reset_n) return;
    m_sw_old = m_sw_mid;
    m_sw_mid = sw_in;
    if (!m_run) begin
      if (ld_valid && ld_addr < 8'hF0) m_mem[ld_addr] = ld_data;
      if (ld_done) m_run = 1'b1;
    end else begin
      if (mem_write && a < 8'hF0) m_mem[a] = wdata;
      if (mem_write && a == 8'hF0) m_led = wdata;
      if (mem_write && a == 8'hF2) m_cnt = 16'h0;
      else m_cnt = m_cnt + 16'h1;
    end
  endtask

  task automatic push_exp(input string nm);
    logic [7:0] a;
    a = mem_addr_sel ? ir_addr : pc;
    exp_q.push_back({(data_bus_sel == 2'b01) && m_run, !m_run, m_run, !m_run,
                     m_led, m_read(a)});
    name_q.push_back(nm);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set at posedge+1; one call spans one clock cycle.
  task automatic cycle(input bit chk, input string nm);
    if (chk) push_exp(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    mem_addr_sel = 1'b0; mem_write = 1'b0; data_bus_sel = 2'b00;
    wdata = 16'h0; ld_valid = 1'b0; ld_addr = 8'h0; ld_data = 16'h0;
    ld_done = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    idle_inputs();
    pc = a; data_bus_sel = 2'b01;
    cycle(1'b1, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input string nm);
    idle_inputs();
    mem_addr_sel = 1'b1; ir_addr = a; mem_write = 1'b1; wdata = d;
    cycle(1'b1, nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e, g;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {mem_drive, cpu_hold, boot_done, ld_ready, led_out, rdata};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s: got drv/hold/boot/rdy=%b led=%h rdata=%h, expected drv/hold/boot/rdy=%b led=%h rdata=%h",
                   nm, g[35:32], g[31:16], g[15:0], e[35:32], e[31:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    pc = 8'h0; ir_addr = 8'h0; sw_in = 8'h0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    cycle(1'b1, "reset_state");
    reset_n = 1'b1;

    // BOOT: fill RAM with random data, reading back earlier words meanwhile;
    // controller writes here must be ignored.
    for (int a = 0; a < 240; a++) begin
      idle_inputs();
      ld_valid = 1'b1; ld_addr = 8'(a); ld_data = 16'($urandom);
      pc = (a == 0) ? 8'hF3 : 8'(a - 1);
      data_bus_sel = 2'($urandom_range(0, 3));
      mem_write = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      cycle(a % 16 == 0, "boot_fill_rd");
    end

    // loader write into MMIO window is dropped
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 8'hF0; ld_data = 16'hDEAD;
    cycle(1'b1, "boot_ld_io");
    rd(8'hF0, "boot_led_zero");
    // controller write in BOOT is ignored
    idle_inputs();
    pc = 8'h05; mem_write = 1'b1; wdata = 16'hBEEF;
    cycle(1'b1, "boot_mw_ignored");
    rd(8'h05, "boot_ram5_kept");

    // loader writes; last one together with ld_done
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'hA5A5;
    cycle(1'b0, "");
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 8'h10; ld_data = 16'h1234; ld_done = 1'b1;
    cycle(1'b1, "boot_last_ld");

    // RUN
    rd(8'h00, "run_rd_00");
    idle_inputs();
    mem_addr_sel = 1'b1; ir_addr = 8'h10; pc = 8'h00; data_bus_sel = 2'b01;
    cycle(1'b1, "run_rd_ir_10");
    rd(8'h05, "run_ram5");
    for (int i = 0; i < 8; i++) rd(8'hF2, "cnt_run");
    rd(8'hF3, "status_run");

    // LED
    wr(8'hF0, 16'h00FF, "led_wr");
    rd(8'hF0, "led_rd");
    wr(8'hF1, 16'h1111, "sw_wr_ignored");
    rd(8'hF0, "led_after_f1");
    rd(8'hF4, "io_unmapped");

    // switch synchroniser latency
    pc = 8'hF1; sw_in = 8'h5A;
    for (int i = 0; i < 4; i++) rd(8'hF1, "sw_latency");

    // counter clear
    wr(8'hF2, 16'hFFFF, "cnt_clear_wr");
    rd(8'hF2, "cnt_after_clear");
    rd(8'hF2, "cnt_after_clear2");

    // read-during-write
    wr(8'h20, 16'h7777, "rdw_old");
    rd(8'h20, "rdw_new");

    // random RUN traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 239))
                                      : 8'($urandom_range(240, 255));
      mem_addr_sel = 1'($urandom_range(0, 1));
      if (mem_addr_sel) begin ir_addr = a; pc = 8'($urandom); end
      else begin pc = a; ir_addr = 8'($urandom); end
      mem_write    = ($urandom_range(0, 3) == 0);
      data_bus_sel = 2'($urandom_range(0, 3));
      wdata        = 16'($urandom);
      if ($urandom_range(0, 7) == 0) sw_in = 8'($urandom);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 8'($urandom);
      ld_data  = 16'($urandom);
      ld_done  = 1'($urandom_range(0, 1));
      cycle(1'b1, "rand_run");
    end

    // counter wrap: clear, then count up past 16'hFFFF
    wr(8'hF2, 16'h0, "wrap_clear");
    idle_inputs();
    pc = 8'hF2;
    for (int i = 0; i < 65533; i++) cycle(1'b0, "");
    for (int i = 0; i < 4; i++) rd(8'hF2, "cnt_wrap");

    // reset mid-RUN: hold must rise before the next clock edge
    idle_inputs();
    pc = 8'h20; data_bus_sel = 2'b01;
    reset_n = 1'b0;
    model_reset();
    cycle(1'b1, "rst_async_hold");
    reset_n = 1'b1;
    rd(8'h20, "rst_ram_kept_boot");
    idle_inputs();
    pc = 8'h20; ld_done = 1'b1;
    cycle(1'b1, "rst_ld_done");
    rd(8'h20, "rst_ram_kept_run");
    rd(8'hF2, "rst_cnt");
    rd(8'hF0, "rst_led");

    idle_inputs();
    cycle(1'b0, "");
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder to the processor controller's memory control signals (mem_write, mem_addr_sel, data_bus_sel).
- Selects the address from either PC or the IR address field, then serves asynchronous reads and clocked writes to a unified instruction/data RAM and a small memory-mapped I/O window.
- Also owns the boot phase: an external loader port fills RAM while the CPU is held, then the block releases the CPU into RUN.

Parameters:
DATA_W, 16, data bus / word width
ADDR_W, 8, address width (PC and IR address field)
IO_BASE, 8'hF0, first address of the MMIO window; RAM spans 0..IO_BASE-1
SW_W, 8, width of the switch input

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pc  in  ADDR_W  program counter
ir_addr  in  ADDR_W  instruction address field
mem_addr_sel  in  1  address select: 0 = pc, 1 = ir_addr
mem_write  in  1  write strobe from the controller
data_bus_sel  in  2  bus source; 2'b01 = memory drives the bus
wdata  in  DATA_W  data bus value to write (register file output)
rdata  out  DATA_W  read data toward the data bus
mem_drive  out  1  high when data_bus_sel == 2'b01 in RUN
sw_in  in  SW_W  asynchronous switch inputs
led_out  out  DATA_W  LED register
ld_valid  in  1  loader write request
ld_addr  in  ADDR_W  loader address
ld_data  in  DATA_W  loader data
ld_done  in  1  loader finished (pulse or level)
ld_ready  out  1  loader write accepted this cycle
cpu_hold  out  1  holds the controller in reset/stall while high
boot_done  out  1  high in RUN

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = BOOT, cpu_hold = 1, boot_done = 0, led_out = 0.
  - Cycle counter = 0; switch synchronizer flops = 0.
  - RAM contents are not reset.
- State machine has two states:
  - BOOT: ld_ready = 1. On each clk edge with ld_valid = 1 and ld_addr < IO_BASE, write ld_data to RAM[ld_addr]. Loader writes with ld_addr >= IO_BASE are dropped. Controller mem_write is ignored.
  - BOOT -> RUN: on the edge where ld_done = 1. A ld_valid in the same cycle is still committed.
  - RUN: cpu_hold = 0, boot_done = 1, ld_ready = 0. Loader inputs are ignored. RUN exits only through reset.
- Address: addr = mem_addr_sel ? ir_addr : pc.
- Read, combinational, 0-cycle latency (FETCH loads IR in the same cycle):
  - addr < IO_BASE -> RAM[addr].
  - IO_BASE+0 -> led_out.
  - IO_BASE+1 -> zero-extended, 2-flop-synchronised sw_in.
  - IO_BASE+2 -> cycle counter.
  - IO_BASE+3 -> {zeros, boot_done}.
  - Any other I/O address -> 0.
- rdata is valid regardless of data_bus_sel. mem_drive = (data_bus_sel == 2'b01) && RUN.
- Write (RUN, mem_write = 1) commits at the clk edge:
  - RAM address -> RAM[addr] <= wdata.
  - IO_BASE+0 -> led_out <= wdata.
  - IO_BASE+2 -> counter <= 0; the clear wins over the increment.
  - Other I/O addresses -> ignored.
- Read-during-write to the same address in the same cycle returns the old value; the new value is visible the next cycle.
- Cycle counter: free-running DATA_W bits, counts in RUN only, wraps 16'hFFFF -> 0.
- Switch value read at IO_BASE+1 reflects sw_in with 2 cycles of latency.
- Reset asserted mid-RUN: the block returns to BOOT and the CPU is held again. RAM is preserved, so the loader may reload or just pulse ld_done.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, IO_BASE, MMIO offsets (IO_LED = 0, IO_SW = 1, IO_CNT = 2, IO_STAT = 3), data_bus_sel encodings (BUS_ALU = 2'b00, BUS_MEM = 2'b01, BUS_RF = 2'b10).
- One natural sub-module: mmio_regs, containing the LED register, switch synchronizer, counter and status read mux. The RAM array and the boot FSM stay in the top module.

Test Plan:
- Reset, then loader writes 16'hA5A5 @0x00 and 16'h1234 @0x10, pulse ld_done -> boot_done = 1 next cycle; pc = 0x00 gives rdata = A5A5; mem_addr_sel = 1, ir_addr = 0x10 gives rdata = 1234.
- In BOOT: mem_write = 1, addr 0x05, wdata 0xBEEF -> RAM[0x05] unchanged. Loader write to 0xF0 -> led_out stays 0.
- In RUN: write 0x00FF to 0xF0 -> led_out = 0x00FF next cycle; read 0xF0 returns 0x00FF. Write to 0xF1 -> no effect.
- sw_in = 0x5A in RUN -> read at 0xF1 returns 0x005A from the 2nd edge after the change, old value before that.
- Counter: 10 RUN cycles after boot reads 10. Write to 0xF2 -> reads 0 next cycle. Preload to 0xFFFF via cycles -> wraps to 0.
- Same-cycle write 0x7777 and read at 0x20 returns the old value; next cycle returns 0x7777. reset_n pulse mid-RUN -> cpu_hold = 1 asynchronously, RAM[0x20] still 0x7777 after ld_done.
